// File: rtl/pe_instr_queue.sv
// ---------------------------------------------------------------------------
// pe_instr_queue
//
// Instruction issue queue between fetch and the opcode decoder. Words arrive
// under valid/ready, are pre-decoded at enqueue (major opcode, function field,
// arith / illegal class) and stored with the raw word. The head entry is then
// presented to decode under valid/ready. A synchronous flush empties the
// queue, and a saturating counter tracks how many illegal words were issued.
//
// Parameters
//   DEPTH        number of entries (power of two, >= 2)
//   ERR_W        width of the illegal-instruction counter
//
// Ports
//   clk          core clock, rising-edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear, wins over push and pop
//   in_valid     fetch presents a word on in_instr
//   in_ready     queue can take a word this cycle
//   in_instr     32-bit instruction word
//   out_valid    head entry is presented to decode
//   out_ready    decode consumes the head this cycle
//   out_instr    head instruction word (0 when !out_valid)
//   out_opcode   head bits [31:25]     (0 when !out_valid)
//   out_func     head bits [24:20]     (0 when !out_valid)
//   out_is_arith head opcode is ARITH  (0 when !out_valid)
//   out_illegal  head opcode not legal (0 when !out_valid)
//   count        entries currently held
//   illegal_cnt  illegal words issued, saturating, cleared only by rst_n
// ---------------------------------------------------------------------------
module pe_instr_queue #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_func,
  output logic                     out_is_arith,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ERR_W-1:0]         illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [6:0] {
    OP_NOP    = 7'b0000000,
    OP_ARITH  = 7'b0000001,
    OP_LOAD   = 7'b0000010,
    OP_STORE  = 7'b0000011,
    OP_BRANCH = 7'b0000100
  } opcode_e;

  // One stored entry: raw word plus the decode computed when it was enqueued.
  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  func;
    logic        is_arith;
    logic        illegal;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           in_entry;
  entry_t           head;
  logic             push;
  logic             pop;

  // -------------------------------------------------------------------------
  // Handshake. in_ready deliberately ignores out_ready: a full queue does not
  // accept a word even if the head leaves in the same cycle.
  // -------------------------------------------------------------------------
  assign in_ready  = rst_n && !flush && (count < FULL_CNT);
  assign out_valid = (count != '0) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // Pre-decode of the incoming word. func is carried along but not checked.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_entry          = '0;
    in_entry.instr    = in_instr;
    in_entry.opcode   = in_instr[31:25];
    in_entry.func     = in_instr[24:20];
    in_entry.is_arith = (in_instr[31:25] == OP_ARITH);
    unique case (in_instr[31:25])
      OP_NOP, OP_ARITH, OP_LOAD, OP_STORE, OP_BRANCH: in_entry.illegal = 1'b0;
      default:                                        in_entry.illegal = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage. Written only on an accepted push; read at rd_ptr.
  // -------------------------------------------------------------------------
  // NOTE: the entry array has no reset. Its contents are only observed while
  // count says they are valid, so clearing it would buy nothing and would
  // stop it mapping onto plain register-file / RAM cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  assign head = mem[rd_ptr];

  // -------------------------------------------------------------------------
  // Pointers and occupancy. Pointers are log2(DEPTH) wide, so they wrap
  // modulo DEPTH by plain overflow. Flush cannot coincide with push or pop
  // because it forces in_ready and out_valid low.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Illegal-issue counter: bumps when an illegal head is consumed, sticks at
  // all-ones, and survives flush.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (pop && head.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + ERR_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Head presentation: stored decode, forced to zero when nothing is valid.
  // -------------------------------------------------------------------------
  always_comb begin
    out_instr    = '0;
    out_opcode   = '0;
    out_func     = '0;
    out_is_arith = 1'b0;
    out_illegal  = 1'b0;
    if (out_valid) begin
      out_instr    = head.instr;
      out_opcode   = head.opcode;
      out_func     = head.func;
      out_is_arith = head.is_arith;
      out_illegal  = head.illegal;
    end
  end

endmodule
